icb_cfg_master: RTL and testbench

ICB_CFG_MASTER -- requirements
Module: icb_cfg_master

---
 rtl/icb_cfg_pkg.sv | 15 +
 rtl/icb_cmd_fifo.sv | 53 +++++
 rtl/icb_cfg_master.sv | 148 ++++++++++++++
 tb/tb_icb_cfg_master.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/icb_cfg_pkg.sv
// Shared widths, FSM state encoding and queued command record for the ICB config master.
package icb_cfg_pkg;
   localparam int ICB_AW = 8;
   localparam int ICB_DW = 32;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

   typedef struct packed {
      logic              wr;
      logic [ICB_AW-1:0] adr;
      logic [ICB_DW-1:0] wdat;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);
endpackage

// File: rtl/icb_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; head entry is visible on dout without a pop.
module icb_cmd_fifo #(
   parameter int W     = 41,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] cnt;
   logic          do_push, do_pop;

   // Explicit wrap keeps non-power-of-two depths correct.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rptr];

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) wptr <= ptr_inc(wptr);
         if (do_pop)  rptr <= ptr_inc(rptr);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end
endmodule

// File: rtl/icb_cfg_master.sv
// Queues config commands and issues them one at a time on ICB, with ack timeout and
// a held response channel.
module icb_cfg_master
   import icb_cfg_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ICB_AW-1:0] cmd_adr,
   input  logic [ICB_DW-1:0] cmd_wdat,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_wr,
   output logic [ICB_DW-1:0] rsp_rdat,
   output logic              rsp_err,
   output logic              icb_wr,
   output logic [ICB_AW-1:0] icb_wadr,
   output logic [ICB_DW-1:0] icb_wdat,
   input  logic              icb_wack,
   output logic              icb_rd,
   output logic [ICB_AW-1:0] icb_radr,
   input  logic [ICB_DW-1:0] icb_rdat,
   input  logic              icb_rack,
   output logic              busy
);
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;

   state_t            state, state_nx;
   logic [TW-1:0]     tmr, tmr_nx;
   logic              wr_nx, rd_nx;
   logic [ICB_AW-1:0] wadr_nx, radr_nx;
   logic [ICB_DW-1:0] wdat_nx, rsp_rdat_nx;
   logic              rsp_valid_nx, rsp_wr_nx, rsp_err_nx;
   logic              fifo_full, fifo_empty, pop;
   cmd_t              in_cmd, head;

   assign in_cmd.wr   = cmd_wr;
   assign in_cmd.adr  = cmd_adr;
   assign in_cmd.wdat = cmd_wdat;

   icb_cmd_fifo #(.W(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_  (rst_),
      .push  (cmd_valid & cmd_ready),
      .din   (in_cmd),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign cmd_ready = ~fifo_full;
   assign busy      = ~fifo_empty | (state != S_IDLE);

   always_comb begin
      state_nx     = state;
      tmr_nx       = tmr;
      wr_nx        = icb_wr;
      rd_nx        = icb_rd;
      wadr_nx      = icb_wadr;
      wdat_nx      = icb_wdat;
      radr_nx      = icb_radr;
      rsp_valid_nx = rsp_valid;
      rsp_wr_nx    = rsp_wr;
      rsp_rdat_nx  = rsp_rdat;
      rsp_err_nx   = rsp_err;
      pop          = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop    = 1'b1;
               wr_nx  = head.wr;
               rd_nx  = ~head.wr;
               if (head.wr) begin
                  wadr_nx = head.adr;
                  wdat_nx = head.wdat;
               end else begin
                  radr_nx = head.adr;
               end
               tmr_nx   = '0;
               state_nx = S_REQ;
            end
         end
         S_REQ: begin
            // Only the ack matching the live request counts.
            if ((icb_wr && icb_wack) || (icb_rd && icb_rack)) begin
               wr_nx        = 1'b0;
               rd_nx        = 1'b0;
               rsp_valid_nx = 1'b1;
               rsp_wr_nx    = icb_wr;
               rsp_rdat_nx  = icb_rd ? icb_rdat : '0;
               rsp_err_nx   = 1'b0;
               state_nx     = S_RSP;
            end else if (tmr == TW'(TIMEOUT_CYC - 1)) begin
               wr_nx        = 1'b0;
               rd_nx        = 1'b0;
               rsp_valid_nx = 1'b1;
               rsp_wr_nx    = icb_wr;
               rsp_rdat_nx  = '0;
               rsp_err_nx   = 1'b1;
               state_nx     = S_RSP;
            end else if (tmr != '1) begin
               tmr_nx = tmr + TW'(1);
            end
         end
         S_RSP: begin
            if (rsp_ready) begin
               rsp_valid_nx = 1'b0;
               state_nx     = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state     <= S_IDLE;
         tmr       <= '0;
         icb_wr    <= 1'b0;
         icb_rd    <= 1'b0;
         icb_wadr  <= '0;
         icb_wdat  <= '0;
         icb_radr  <= '0;
         rsp_valid <= 1'b0;
         rsp_wr    <= 1'b0;
         rsp_rdat  <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nx;
         tmr       <= tmr_nx;
         icb_wr    <= wr_nx;
         icb_rd    <= rd_nx;
         icb_wadr  <= wadr_nx;
         icb_wdat  <= wdat_nx;
         icb_radr  <= radr_nx;
         rsp_valid <= rsp_valid_nx;
         rsp_wr    <= rsp_wr_nx;
         rsp_rdat  <= rsp_rdat_nx;
         rsp_err   <= rsp_err_nx;
      end
   end
endmodule

// File: tb/tb_icb_cfg_master.sv
// Directed vector bench for icb_cfg_master with a small mode-selectable ICB responder.
module tb_icb_cfg_master;
   logic        clk = 1'b0, rst_ = 1'b0;
   logic        cmd_valid = 1'b0, cmd_wr = 1'b0, rsp_ready = 1'b0;
   logic [7:0]  cmd_adr = '0;
   logic [31:0] cmd_wdat = '0;
   logic        cmd_ready, rsp_valid, rsp_wr, rsp_err, busy;
   logic [31:0] rsp_rdat;
   logic        icb_wr, icb_rd, icb_wack, icb_rack;
   logic [7:0]  icb_wadr, icb_radr;
   logic [31:0] icb_wdat, icb_rdat;

   // Responder: 0 = silent, 1 = same-cycle ack, 2 = ack one cycle after request
   int          mode = 0;
   logic        f_wack = 1'b0, f_rack = 1'b0, adr_echo = 1'b0, ack_q;
   logic [31:0] rdat_val = '0;
   int          errors = 0, checks = 0;

   assign icb_wack = f_wack | ((mode == 1) && icb_wr) | ((mode == 2) && ack_q && icb_wr);
   assign icb_rack = f_rack | ((mode == 1) && icb_rd) | ((mode == 2) && ack_q && icb_rd);
   assign icb_rdat = adr_echo ? {8'hEC, 16'h0, icb_radr} : rdat_val;

   always @(posedge clk or negedge rst_)
      if (!rst_) ack_q <= 1'b0;
      else       ack_q <= (icb_wr | icb_rd) & ~ack_q;

   always #5 clk = ~clk;

   icb_cfg_master #(.TIMEOUT_CYC(16), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_(rst_),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_adr(cmd_adr), .cmd_wdat(cmd_wdat),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
      .rsp_rdat(rsp_rdat), .rsp_err(rsp_err),
      .icb_wr(icb_wr), .icb_wadr(icb_wadr), .icb_wdat(icb_wdat), .icb_wack(icb_wack),
      .icb_rd(icb_rd), .icb_radr(icb_radr), .icb_rdat(icb_rdat), .icb_rack(icb_rack),
      .busy(busy)
   );

   typedef struct {
      logic        wr;
      logic [7:0]  adr;
      logic [31:0] wdat;
      int          mode;
      logic [31:0] rdat;
      int          exp_hi;
      logic        exp_err;
      logic [31:0] exp_rdat;
   } vec_t;

   vec_t vt[7];
   vec_t post;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Issue one command, measure request width and latency, check and consume the response.
   task automatic run_vec(input vec_t v, input string tag, input bit rel);
      int          hi, lat;
      logic        done, saw_wr, saw_rd;
      logic [7:0]  g_adr;
      logic [31:0] g_wdat;
      @(negedge clk);
      if (rel) rst_ = 1'b1;
      mode = v.mode; rdat_val = v.rdat;
      cmd_valid = 1'b1; cmd_wr = v.wr; cmd_adr = v.adr; cmd_wdat = v.wdat;
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      hi = 0; lat = 0; done = 1'b0; saw_wr = 1'b0; saw_rd = 1'b0; g_adr = '0; g_wdat = '0;
      for (int i = 0; i < 60 && !done; i++) begin
         if (icb_wr && icb_rd) chk({tag, "_wr_rd_both"}, 32'd1, 32'd0);
         if (icb_wr || icb_rd) begin
            if (hi == 0) begin
               saw_wr = icb_wr; saw_rd = icb_rd;
               g_adr  = icb_wr ? icb_wadr : icb_radr;
               g_wdat = icb_wdat;
            end
            hi++;
         end
         if (rsp_valid) done = 1'b1;
         else begin lat++; @(negedge clk); end
      end
      chk({tag, "_rsp_seen"}, 32'(done), 32'd1);
      chk({tag, "_req_cycles"}, 32'(hi), 32'(v.exp_hi));
      chk({tag, "_latency"}, 32'(lat), 32'(v.exp_hi + 1));
      chk({tag, "_req_kind"}, {30'd0, saw_wr, saw_rd}, {30'd0, v.wr, ~v.wr});
      chk({tag, "_icb_adr"}, 32'(g_adr), 32'(v.adr));
      if (v.wr) chk({tag, "_icb_wdat"}, g_wdat, v.wdat);
      chk({tag, "_rsp_wr"}, 32'(rsp_wr), 32'(v.wr));
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
      chk({tag, "_rsp_rdat"}, rsp_rdat, v.exp_rdat);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, "_rsp_cleared"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, k, stale;
      logic rdy;
      vt[0] = '{1'b1, 8'h00, 32'h0040_0000, 2, 32'h0000_0000,  2, 1'b0, 32'h0000_0000};
      vt[1] = '{1'b0, 8'h01, 32'h0000_0000, 1, 32'h0000_0001,  1, 1'b0, 32'h0000_0001};
      vt[2] = '{1'b0, 8'h05, 32'h0000_0000, 0, 32'hDEAD_BEEF, 16, 1'b1, 32'h0000_0000};
      vt[3] = '{1'b0, 8'h22, 32'h0000_0000, 1, 32'hCAFE_F00D,  1, 1'b0, 32'hCAFE_F00D};
      vt[4] = '{1'b1, 8'h7F, 32'hA5A5_5A5A, 1, 32'hFFFF_FFFF,  1, 1'b0, 32'h0000_0000};
      vt[5] = '{1'b0, 8'hFF, 32'h0000_0000, 2, 32'h1234_5678,  2, 1'b0, 32'h1234_5678};
      vt[6] = '{1'b1, 8'h10, 32'h1357_9BDF, 0, 32'h0000_0000, 16, 1'b1, 32'h0000_0000};
      post  = '{1'b1, 8'h3C, 32'h0F0F_0F0F, 1, 32'h0000_0000,  1, 1'b0, 32'h0000_0000};

      // Reset state
      #12;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_icb_req", {30'd0, icb_wr, icb_rd}, 32'd0);
      chk("rst_rsp_rdat", rsp_rdat, 32'd0);

      // First command offered at the release edge
      run_vec(vt[0], "v0", 1'b1);
      for (int i = 1; i < 7; i++) run_vec(vt[i], $sformatf("v%0d", i), 1'b0);

      // Stray acks in IDLE, wrong-direction ack during a read, ack during RSP
      mode = 0;
      @(negedge clk); f_wack = 1'b1; f_rack = 1'b1;
      @(negedge clk); f_wack = 1'b0; f_rack = 1'b0;
      chk("idle_ack_busy", 32'(busy), 32'd0);
      chk("idle_ack_rsp", 32'(rsp_valid), 32'd0);
      rdat_val = 32'h0BAD_F00D;
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_adr = 8'h33;
      @(negedge clk); cmd_valid = 1'b0;
      @(negedge clk);
      chk("xack_rd_up", 32'(icb_rd), 32'd1);
      f_wack = 1'b1;
      @(negedge clk); @(negedge clk); f_wack = 1'b0;
      chk("xack_rd_held", 32'(icb_rd), 32'd1);
      chk("xack_no_rsp", 32'(rsp_valid), 32'd0);
      f_rack = 1'b1;
      @(negedge clk); f_rack = 1'b0;
      chk("xack_rd_done", {30'd0, icb_rd, rsp_valid}, 32'd1);
      chk("xack_rdat", rsp_rdat, 32'h0BAD_F00D);
      chk("xack_err", 32'(rsp_err), 32'd0);
      rdat_val = 32'h1111_1111; f_rack = 1'b1;
      @(negedge clk); f_rack = 1'b0;
      chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_hold_rdat", rsp_rdat, 32'h0BAD_F00D);
      rsp_ready = 1'b1;
      @(negedge clk); rsp_ready = 1'b0;

      // Backpressure: 1 in flight + 4 queued, then ordered drain
      mode = 2; adr_echo = 1'b1; acc = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_adr = 8'h40 + 8'(i);
         rdy = cmd_ready;
         if (i == 5) chk("bp_6th_ready", 32'(rdy), 32'd0);
         @(posedge clk);
         if (rdy) acc++;
      end
      @(negedge clk); cmd_valid = 1'b0;
      chk("bp_accepted", 32'(acc), 32'd5);
      chk("bp_full", 32'(cmd_ready), 32'd0);
      rsp_ready = 1'b1; k = 0;
      for (int c = 0; c < 200 && k < 5; c++) begin
         if (rsp_valid) begin
            chk($sformatf("bp_drain%0d", k), rsp_rdat, 32'hEC00_0040 + 32'(k));
            k++;
         end
         @(negedge clk);
      end
      chk("bp_drain_count", 32'(k), 32'd5);
      rsp_ready = 1'b0; adr_echo = 1'b0;
      repeat (4) @(negedge clk);
      chk("bp_idle", 32'(busy), 32'd0);
      chk("bp_ready", 32'(cmd_ready), 32'd1);

      // Async reset while a write is in flight and another is queued
      mode = 0;
      @(negedge clk); cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_adr = 8'h99; cmd_wdat = 32'h5555_AAAA;
      @(negedge clk); cmd_wr = 1'b0; cmd_adr = 8'h9A;
      @(negedge clk); cmd_valid = 1'b0;
      chk("prerst_wr", 32'(icb_wr), 32'd1);
      #2 rst_ = 1'b0;
      #1;
      chk("arst_wr", 32'(icb_wr), 32'd0);
      chk("arst_rsp", 32'(rsp_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk); rst_ = 1'b1; mode = 1; stale = 0;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid || icb_wr || icb_rd || busy) stale++;
      end
      chk("no_stale", 32'(stale), 32'd0);
      @(negedge clk); rst_ = 1'b0;
      run_vec(post, "post_rst", 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
